// File: rtl/build_info_loader_if.sv
// Valid/ready byte-stream handshake between a byte source and the build-info loader.
interface build_info_loader_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/build_info_loader.sv
// Hunts for SYNC-framed build-info records on a byte stream, validates them and
// atomically publishes core_id / commit_id / dirty on every good frame.
module build_info_loader #(
    parameter int unsigned TIMEOUT = 1024,
    parameter logic [7:0]  SYNC    = 8'hA5
) (
    input  logic               clk,
    input  logic               rst_n,
    build_info_loader_if.slave stream,
    output logic [31:0]        core_id,
    output logic [39:0]        commit_id,
    output logic               dirty,
    output logic               info_valid,
    output logic               err_pulse,
    output logic [7:0]         err_cnt
);
    typedef enum logic [2:0] {
        ST_HUNT    = 3'd0,
        ST_CORE    = 3'd1,
        ST_COMMIT  = 3'd2,
        ST_FLAGS   = 3'd3,
        ST_CSUM    = 3'd4,
        ST_PUBLISH = 3'd5
    } state_t;

    // The gap expires on the edge where the counter would reach TIMEOUT.
    localparam logic [15:0] IDLE_LAST = 16'(TIMEOUT - 32'd1);

    state_t      state_r, state_next_s;
    logic [3:0]  idx_r;
    logic [15:0] idle_r;
    logic [31:0] core_sh_r;
    logic [39:0] commit_sh_r;
    logic [7:0]  flags_sh_r;
    logic [7:0]  xor_r;
    logic        in_ready_r;
    logic [31:0] core_id_r;
    logic [39:0] commit_id_r;
    logic        dirty_r;
    logic        info_valid_r;
    logic        err_pulse_r;
    logic [7:0]  err_cnt_r;

    logic accept_s, in_frame_s, timeout_s, frame_ok_s;
    logic drop_s, publish_s, ready_next_s;

    assign accept_s   = stream.in_valid && in_ready_r;
    assign in_frame_s = (state_r == ST_CORE) || (state_r == ST_COMMIT) ||
                        (state_r == ST_FLAGS) || (state_r == ST_CSUM);
    assign timeout_s  = in_frame_s && !accept_s && (idle_r == IDLE_LAST);
    assign frame_ok_s = (stream.in_data == xor_r) && (flags_sh_r[7:1] == 7'd0);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_HUNT;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode; inside a frame SYNC is plain data.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_HUNT: begin
                if (accept_s && (stream.in_data == SYNC)) state_next_s = ST_CORE;
                else                                      state_next_s = ST_HUNT;
            end
            ST_CORE: begin
                if (timeout_s)                          state_next_s = ST_HUNT;
                else if (accept_s && (idx_r == 4'd3))   state_next_s = ST_COMMIT;
                else                                    state_next_s = ST_CORE;
            end
            ST_COMMIT: begin
                if (timeout_s)                          state_next_s = ST_HUNT;
                else if (accept_s && (idx_r == 4'd4))   state_next_s = ST_FLAGS;
                else                                    state_next_s = ST_COMMIT;
            end
            ST_FLAGS: begin
                if (timeout_s)     state_next_s = ST_HUNT;
                else if (accept_s) state_next_s = ST_CSUM;
                else               state_next_s = ST_FLAGS;
            end
            ST_CSUM: begin
                if (timeout_s)                   state_next_s = ST_HUNT;
                else if (accept_s && frame_ok_s) state_next_s = ST_PUBLISH;
                else if (accept_s)               state_next_s = ST_HUNT;
                else                             state_next_s = ST_CSUM;
            end
            ST_PUBLISH: state_next_s = ST_HUNT;
            default:    state_next_s = ST_HUNT;
        endcase
    end

    // Output decode: drop/publish strobes and next value of the ready register.
    always_comb begin
        drop_s    = 1'b0;
        publish_s = 1'b0;
        case (state_r)
            ST_HUNT:    drop_s    = 1'b0;
            ST_CSUM:    drop_s    = timeout_s || (accept_s && !frame_ok_s);
            ST_PUBLISH: publish_s = 1'b1;
            default:    drop_s    = timeout_s;
        endcase
        ready_next_s = (state_next_s != ST_PUBLISH);
    end

    // Frame datapath: idle counter, byte index, shadow fields and running XOR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_r      <= 16'd0;
            idx_r       <= 4'd0;
            core_sh_r   <= 32'd0;
            commit_sh_r <= 40'd0;
            flags_sh_r  <= 8'd0;
            xor_r       <= 8'd0;
        end else begin
            if (accept_s || !in_frame_s || timeout_s) idle_r <= 16'd0;
            else                                      idle_r <= idle_r + 16'd1;

            if (state_next_s != state_r) idx_r <= 4'd0;
            else if (accept_s && ((state_r == ST_CORE) || (state_r == ST_COMMIT)))
                idx_r <= idx_r + 4'd1;
            else idx_r <= idx_r;

            case (state_r)
                ST_HUNT: begin
                    if (accept_s && (stream.in_data == SYNC)) xor_r <= 8'd0;
                    else                                      xor_r <= xor_r;
                end
                ST_CORE: begin
                    if (accept_s) begin
                        core_sh_r <= {core_sh_r[23:0], stream.in_data};
                        xor_r     <= xor_r ^ stream.in_data;
                    end
                end
                ST_COMMIT: begin
                    if (accept_s) begin
                        commit_sh_r <= {commit_sh_r[31:0], stream.in_data};
                        xor_r       <= xor_r ^ stream.in_data;
                    end
                end
                ST_FLAGS: begin
                    if (accept_s) begin
                        flags_sh_r <= stream.in_data;
                        xor_r      <= xor_r ^ stream.in_data;
                    end
                end
                default: xor_r <= xor_r;
            endcase
        end
    end

    // Published outputs, error strobe/counter and the registered ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_r   <= 1'b0;
            err_pulse_r  <= 1'b0;
            err_cnt_r    <= 8'd0;
            core_id_r    <= 32'd0;
            commit_id_r  <= 40'd0;
            dirty_r      <= 1'b0;
            info_valid_r <= 1'b0;
        end else begin
            in_ready_r  <= ready_next_s;
            err_pulse_r <= drop_s;
            if (drop_s && (err_cnt_r != 8'hFF)) err_cnt_r <= err_cnt_r + 8'd1;
            if (publish_s) begin
                core_id_r    <= core_sh_r;
                commit_id_r  <= commit_sh_r;
                dirty_r      <= flags_sh_r[0];
                info_valid_r <= 1'b1;
            end
        end
    end

    assign stream.in_ready = in_ready_r;
    assign core_id         = core_id_r;
    assign commit_id       = commit_id_r;
    assign dirty           = dirty_r;
    assign info_valid      = info_valid_r;
    assign err_pulse       = err_pulse_r;
    assign err_cnt         = err_cnt_r;

endmodule

// File: tb/tb_build_info_loader.sv
// Bench for build_info_loader: frames are built from field values, and a
// frame-level model decides whether each one publishes or is dropped.
`timescale 1ns/1ps
module tb_build_info_loader;
    localparam int         TMO    = 8;
    localparam logic [7:0] SYNC_B = 8'hA5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    build_info_loader_if bus ();
    logic [31:0] core_id;
    logic [39:0] commit_id;
    logic        dirty, info_valid, err_pulse;
    logic [7:0]  err_cnt;

    build_info_loader #(.TIMEOUT(TMO), .SYNC(SYNC_B)) dut (
        .clk(clk), .rst_n(rst_n), .stream(bus),
        .core_id(core_id), .commit_id(commit_id), .dirty(dirty),
        .info_valid(info_valid), .err_pulse(err_pulse), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic [31:0] exp_core   = 32'd0;
    logic [39:0] exp_commit = 40'd0;
    logic        exp_dirty  = 1'b0;
    logic        exp_info   = 1'b0;
    int exp_err    = 0;
    int exp_pulses = 0;
    int cyc = 0, pulse_seen = 0, ready_low = 0;
    int xfer_log[$];
    logic [7:0] fr [12];

    always @(posedge clk) cyc <= cyc + 1;

    // Observe strobes, ready bubbles and transfers away from the active edge.
    always @(negedge clk) begin
        if (err_pulse === 1'b1) pulse_seen <= pulse_seen + 1;
        if (rst_n === 1'b1 && bus.in_ready === 1'b0) ready_low <= ready_low + 1;
        if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) xfer_log.push_back(cyc);
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic build_frame(input logic [31:0] c, input logic [39:0] m,
                               input logic [7:0] f, input logic [7:0] cx);
        logic [7:0] x;
        fr[0] = SYNC_B;
        for (int i = 0; i < 4; i++) fr[1+i] = c[31-8*i -: 8];
        for (int i = 0; i < 5; i++) fr[5+i] = m[39-8*i -: 8];
        fr[10] = f;
        x = 8'h00;
        for (int i = 1; i <= 10; i++) x = x ^ fr[i];
        fr[11] = x ^ cx;
    endtask

    // A frame publishes only with a correct checksum and clean reserved bits.
    task automatic model_frame(input logic [31:0] c, input logic [39:0] m,
                               input logic [7:0] f, input logic [7:0] cx);
        if (cx == 8'h00 && f[7:1] == 7'd0) begin
            exp_core = c; exp_commit = m; exp_dirty = f[0]; exp_info = 1'b1;
        end else begin
            if (exp_err < 255) exp_err = exp_err + 1;
            exp_pulses = exp_pulses + 1;
        end
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        @(negedge clk);
        while (bus.in_ready !== 1'b1 && n < 4) begin
            @(negedge clk);
            n++;
        end
        if (bus.in_ready !== 1'b1) begin
            tests++; fails++;
            $display("FAIL send_byte: in_ready stuck at %b, required 1", bus.in_ready);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_bytes(input int first, input int last, input int gmin, input int gmax);
        for (int i = first; i <= last; i++) begin
            idle(int'($urandom_range(gmax, gmin)));
            send_byte(fr[i]);
        end
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        rst_n = 1'b0;
        #12;
        tests++;
        if ({core_id, commit_id, dirty, info_valid, err_pulse, err_cnt} !== 83'd0) begin
            fails++;
            $display("FAIL reset_outputs: core %h commit %h dirty %b info %b err %b cnt %0d, required all 0",
                     core_id, commit_id, dirty, info_valid, err_pulse, err_cnt);
        end
        tests++;
        if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b required 0", bus.in_ready); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL ready_after_reset: got %b required 1", bus.in_ready); end
    endtask

    task automatic test_bad_csum();
        // 0x10 turns the correct checksum 0x62 into 0x72
        build_frame(32'h3, 40'hDEADBEEF42, 8'h01, 8'h10);
        model_frame(32'h3, 40'hDEADBEEF42, 8'h01, 8'h10);
        send_bytes(0, 11, 0, 0);
        tests++;
        if (err_pulse !== 1'b1) begin fails++; $display("FAIL bad_csum_pulse: got %b required 1", err_pulse); end
        tests++;
        if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL bad_csum_ready: got %b required 1", bus.in_ready); end
        @(posedge clk); #1;
        tests++;
        if (err_pulse !== 1'b0) begin fails++; $display("FAIL bad_csum_pulse_width: got %b required 0", err_pulse); end
        tests++;
        if (err_cnt !== 8'(exp_err)) begin fails++; $display("FAIL bad_csum_cnt: got %0d required %0d", err_cnt, exp_err); end
        tests++;
        if (info_valid !== exp_info || core_id !== exp_core || commit_id !== exp_commit || dirty !== exp_dirty) begin
            fails++;
            $display("FAIL bad_csum_hold: info %b core %h commit %h dirty %b, required %b %h %h %b",
                     info_valid, core_id, commit_id, dirty, exp_info, exp_core, exp_commit, exp_dirty);
        end
    endtask

    task automatic test_clean();
        logic [31:0] prev_core;
        prev_core = exp_core;
        build_frame(32'h3, 40'hDEADBEEF42, 8'h01, 8'h00);
        model_frame(32'h3, 40'hDEADBEEF42, 8'h01, 8'h00);
        send_bytes(0, 11, 0, 0);
        tests++;
        if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL clean_publish_ready: got %b required 0", bus.in_ready); end
        tests++;
        if (core_id !== prev_core) begin fails++; $display("FAIL clean_early_update: core %h required %h", core_id, prev_core); end
        @(posedge clk); #1;
        tests++;
        if (core_id !== 32'h3 || commit_id !== 40'hDEADBEEF42 || dirty !== 1'b1 || info_valid !== 1'b1) begin
            fails++;
            $display("FAIL clean_publish: core %h commit %h dirty %b info %b, required 00000003 deadbeef42 1 1",
                     core_id, commit_id, dirty, info_valid);
        end
        tests++;
        if (pulse_seen !== exp_pulses) begin fails++; $display("FAIL clean_no_err: pulses %0d required %0d", pulse_seen, exp_pulses); end
        tests++;
        if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL clean_ready_back: got %b required 1", bus.in_ready); end
    endtask

    task automatic test_noise_sync();
        logic [39:0] m;
        m = {8'($urandom), 32'($urandom)};
        fr[0] = 8'h11; fr[1] = 8'h22; fr[2] = 8'h5A;
        send_bytes(0, 2, 0, 1);
        build_frame(32'hA5A5A5A5, m, 8'h00, 8'h00);
        model_frame(32'hA5A5A5A5, m, 8'h00, 8'h00);
        send_bytes(0, 11, 0, 2);
        @(posedge clk); #1;
        tests++;
        if (core_id !== 32'hA5A5A5A5 || commit_id !== m || dirty !== 1'b0) begin
            fails++;
            $display("FAIL noise_sync_frame: core %h commit %h dirty %b, required a5a5a5a5 %h 0", core_id, commit_id, dirty, m);
        end
        tests++;
        if (err_cnt !== 8'(exp_err)) begin fails++; $display("FAIL noise_sync_cnt: got %0d required %0d", err_cnt, exp_err); end
    endtask

    task automatic test_timeout();
        logic [31:0] c;
        logic [39:0] m;
        build_frame(32'($urandom), 40'd0, 8'h00, 8'h00);
        send_bytes(0, 6, 0, 0);
        for (int k = 1; k <= TMO + 1; k++) begin
            @(posedge clk); #1;
            tests++;
            if (err_pulse !== 1'(k == TMO)) begin
                fails++;
                $display("FAIL timeout_pulse: cycle %0d after last byte got %b required %b", k, err_pulse, (k == TMO));
            end
        end
        if (exp_err < 255) exp_err = exp_err + 1;
        exp_pulses = exp_pulses + 1;
        tests++;
        if (err_cnt !== 8'(exp_err)) begin fails++; $display("FAIL timeout_cnt: got %0d required %0d", err_cnt, exp_err); end
        // Longest legal gap between bytes must not time out
        c = 32'($urandom); m = {8'($urandom), 32'($urandom)};
        build_frame(c, m, 8'h01, 8'h00);
        model_frame(c, m, 8'h01, 8'h00);
        send_bytes(0, 11, TMO - 1, TMO - 1);
        tests++;
        if (err_pulse !== 1'b0) begin fails++; $display("FAIL max_gap_pulse: got %b required 0", err_pulse); end
        @(posedge clk); #1;
        tests++;
        if (core_id !== c || commit_id !== m || dirty !== 1'b1) begin
            fails++;
            $display("FAIL after_timeout_frame: core %h commit %h required %h %h", core_id, commit_id, c, m);
        end
    endtask

    task automatic test_random();
        logic [31:0] c;
        logic [39:0] m;
        logic [7:0]  f, cx, b;
        int kind, nnoise;
        for (int n = 0; n < 30; n++) begin
            nnoise = int'($urandom_range(2, 0));
            for (int j = 0; j < nnoise; j++) begin
                b = 8'($urandom);
                if (b == SYNC_B) b = 8'h3C;
                send_byte(b);
            end
            c = 32'($urandom);
            m = {8'($urandom), 32'($urandom)};
            kind = int'($urandom_range(3, 0));
            cx = (kind == 2) ? 8'($urandom_range(255, 1)) : 8'h00;
            f = {(kind == 3) ? 7'($urandom_range(127, 1)) : 7'd0, 1'($urandom)};
            build_frame(c, m, f, cx);
            model_frame(c, m, f, cx);
            send_bytes(0, 11, 0, TMO - 2);
            tests++;
            if (err_pulse !== ((kind >= 2) ? 1'b1 : 1'b0)) begin
                fails++;
                $display("FAIL rand_pulse: frame %0d kind %0d got %b", n, kind, err_pulse);
            end
            @(posedge clk); #1;
            tests++;
            if (core_id !== exp_core || commit_id !== exp_commit || dirty !== exp_dirty || info_valid !== exp_info) begin
                fails++;
                $display("FAIL rand_outputs: frame %0d core %h commit %h dirty %b, required %h %h %b",
                         n, core_id, commit_id, dirty, exp_core, exp_commit, exp_dirty);
            end
            tests++;
            if (err_cnt !== 8'(exp_err)) begin fails++; $display("FAIL rand_cnt: frame %0d got %0d required %0d", n, err_cnt, exp_err); end
        end
        tests++;
        if (pulse_seen !== exp_pulses) begin fails++; $display("FAIL rand_pulse_total: got %0d required %0d", pulse_seen, exp_pulses); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] c0, c1;
        logic [39:0] m0, m1;
        int n0, rl0;
        c0 = 32'($urandom); m0 = {8'($urandom), 32'($urandom)};
        c1 = 32'($urandom); m1 = {8'($urandom), 32'($urandom)};
        n0 = xfer_log.size();
        rl0 = ready_low;
        build_frame(c0, m0, 8'h00, 8'h00); model_frame(c0, m0, 8'h00, 8'h00);
        send_bytes(0, 11, 0, 0);
        build_frame(c1, m1, 8'h01, 8'h00); model_frame(c1, m1, 8'h01, 8'h00);
        send_bytes(0, 11, 0, 0);
        @(posedge clk); #1;
        tests++;
        if (xfer_log.size() - n0 !== 24) begin fails++; $display("FAIL b2b_bytes: got %0d required 24", xfer_log.size() - n0); end
        else begin
            tests++;
            if (xfer_log[n0+12] - xfer_log[n0] !== 13) begin
                fails++; $display("FAIL b2b_period: got %0d cycles required 13", xfer_log[n0+12] - xfer_log[n0]);
            end
            tests++;
            if (xfer_log[n0+11] - xfer_log[n0] !== 11) begin
                fails++; $display("FAIL b2b_contiguous: got %0d cycles required 11", xfer_log[n0+11] - xfer_log[n0]);
            end
        end
        tests++;
        if (ready_low - rl0 !== 2) begin fails++; $display("FAIL b2b_ready_bubbles: got %0d required 2", ready_low - rl0); end
        tests++;
        if (core_id !== c1 || commit_id !== m1 || dirty !== 1'b1) begin
            fails++; $display("FAIL b2b_second: core %h commit %h required %h %h", core_id, commit_id, c1, m1);
        end
    endtask

    task automatic test_reserved();
        build_frame(32'h12345678, 40'h9ABCDEF012, 8'h02, 8'h00);
        model_frame(32'h12345678, 40'h9ABCDEF012, 8'h02, 8'h00);
        send_bytes(0, 11, 0, 1);
        @(posedge clk); #1;
        tests++;
        if (err_cnt !== 8'(exp_err) || core_id !== exp_core) begin
            fails++; $display("FAIL reserved_drop: cnt %0d core %h required %0d %h", err_cnt, core_id, exp_err, exp_core);
        end
        build_frame(32'h12345678, 40'h9ABCDEF012, 8'h81, 8'h55);
        model_frame(32'h12345678, 40'h9ABCDEF012, 8'h81, 8'h55);
        send_bytes(0, 11, 0, 1);
        @(posedge clk); #1;
        tests++;
        if (err_cnt !== 8'(exp_err)) begin fails++; $display("FAIL reserved_single_err: got %0d required %0d", err_cnt, exp_err); end
        tests++;
        if (pulse_seen !== exp_pulses) begin fails++; $display("FAIL reserved_pulses: got %0d required %0d", pulse_seen, exp_pulses); end
    endtask

    task automatic test_mid_reset();
        logic [31:0] c;
        logic [39:0] m;
        build_frame(32'h10203040, 40'h0102030405, 8'h00, 8'h00);
        send_bytes(0, 7, 0, 2);
        rst_n = 1'b0;
        #1;
        tests++;
        if ({core_id, commit_id, dirty, info_valid, err_pulse, err_cnt, bus.in_ready} !== 84'd0) begin
            fails++;
            $display("FAIL mid_reset_clear: core %h commit %h info %b cnt %0d ready %b, required all 0",
                     core_id, commit_id, info_valid, err_cnt, bus.in_ready);
        end
        exp_core = 32'd0; exp_commit = 40'd0; exp_dirty = 1'b0; exp_info = 1'b0; exp_err = 0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        send_bytes(8, 11, 0, 0);
        @(posedge clk); #1;
        tests++;
        if (info_valid !== 1'b0 || core_id !== 32'd0) begin
            fails++; $display("FAIL partial_not_published: info %b core %h required 0 00000000", info_valid, core_id);
        end
        c = 32'($urandom); m = {8'($urandom), 32'($urandom)};
        build_frame(c, m, 8'h00, 8'h00); model_frame(c, m, 8'h00, 8'h00);
        send_bytes(0, 11, 0, 0);
        @(posedge clk); #1;
        tests++;
        if (info_valid !== 1'b1 || core_id !== c || commit_id !== m) begin
            fails++; $display("FAIL post_reset_frame: info %b core %h required 1 %h", info_valid, core_id, c);
        end
    endtask

    task automatic test_saturate();
        logic [31:0] c;
        while (exp_err < 255) begin
            c = 32'($urandom);
            build_frame(c, 40'h0, 8'h00, 8'h01); model_frame(c, 40'h0, 8'h00, 8'h01);
            send_bytes(0, 11, 0, 0);
        end
        @(posedge clk); #1;
        tests++;
        if (err_cnt !== 8'd255) begin fails++; $display("FAIL sat_reach: got %0d required 255", err_cnt); end
        build_frame(32'h0, 40'h0, 8'h00, 8'h01); model_frame(32'h0, 40'h0, 8'h00, 8'h01);
        send_bytes(0, 11, 0, 0);
        tests++;
        if (err_pulse !== 1'b1) begin fails++; $display("FAIL sat_pulse: got %b required 1", err_pulse); end
        @(posedge clk); #1;
        tests++;
        if (err_cnt !== 8'(exp_err)) begin fails++; $display("FAIL sat_hold: got %0d required %0d", err_cnt, exp_err); end
        tests++;
        if (pulse_seen !== exp_pulses || core_id !== exp_core) begin
            fails++; $display("FAIL sat_totals: pulses %0d core %h required %0d %h", pulse_seen, core_id, exp_pulses, exp_core);
        end
    endtask

    initial begin
        test_reset();
        test_bad_csum();
        test_clean();
        test_noise_sync();
        test_timeout();
        test_random();
        test_back_to_back();
        test_reserved();
        test_mid_reset();
        test_saturate();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
